// File: rtl/sw_seq_loader_pkg.sv
// ----------------------------------------------------------------------------
// sw_seq_loader_pkg
// Shared definitions for the Smith-Waterman sequence loader: default job
// lengths, 2-bit nucleotide codes, FSM state encodings and the per-cycle
// payload presented to the scoring core.
// ----------------------------------------------------------------------------
package sw_seq_loader_pkg;

    // Default job geometry (the core expects a 64-symbol reference)
    localparam int unsigned DEF_REF_LEN   = 64;
    localparam int unsigned DEF_QUERY_LEN = 48;
    localparam int unsigned DEF_CNT_W     = 7;
    localparam int unsigned NT_W          = 2;
    localparam int unsigned CHAR_W        = 8;

    // 2-bit nucleotide codes shared with the core
    typedef enum logic [NT_W-1:0] {
        NT_A = 2'b00,
        NT_C = 2'b01,
        NT_G = 2'b10,
        NT_T = 2'b11
    } nt_t;

    // Loader FSM states; encodings shared with the core
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // One serial load beat towards the core
    typedef struct packed {
        logic valid;
        nt_t  data_ref;
        nt_t  data_query;
    } sw_beat_t;

    // ASCII lower-case letters folded to upper case; other bytes pass through
    function automatic logic [CHAR_W-1:0] to_upper(input logic [CHAR_W-1:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return c - 8'h20;
        end
        return c;
    endfunction

endpackage : sw_seq_loader_pkg

// File: rtl/sw_seq_loader_nt_encoder.sv
// ----------------------------------------------------------------------------
// sw_nt_encoder
// Combinational ASCII nucleotide encoder, case-insensitive.
//   in_char [7:0]  ASCII byte from the host
//   code    [1:0]  A=00 C=01 G=10 T=11; 00 for anything else
//   illegal        high when in_char is not one of A/C/G/T (any case)
// ----------------------------------------------------------------------------
module sw_nt_encoder
    import sw_seq_loader_pkg::*;
(
    input  logic [CHAR_W-1:0] in_char,
    output nt_t               code,
    output logic              illegal
);

    logic [CHAR_W-1:0] upper;

    assign upper = to_upper(in_char);

    always_comb begin
        code    = NT_A;
        illegal = 1'b0;
        case (upper)
            8'h41:   code = NT_A;   // 'A'
            8'h43:   code = NT_C;   // 'C'
            8'h47:   code = NT_G;   // 'G'
            8'h54:   code = NT_T;   // 'T'
            default: illegal = 1'b1;
        endcase
    end

endmodule : sw_nt_encoder

// File: rtl/sw_seq_loader.sv
// ----------------------------------------------------------------------------
// sw_seq_loader
// Upstream feeder for the Smith-Waterman scoring core. Collects one reference
// and one query from a host byte stream (ASCII nucleotides), then replays
// them to the core as REF_LEN consecutive valid beats, query riding in the
// first QUERY_LEN beats, and finally holds the host off until the core
// reports finish.
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready host byte handshake (in_ready is combinational)
//   in_char, in_sel   ASCII byte; in_sel 0 = reference, 1 = query
//   sw_valid          load strobe to the core (registered)
//   sw_data_ref       reference symbol to the core (registered)
//   sw_data_query     query symbol to the core, 00 past QUERY_LEN (registered)
//   sw_finish         1-cycle completion pulse from the core
//   busy              high while streaming or waiting for finish
//   err               sticky illegal-character flag for the current job
// ----------------------------------------------------------------------------
module sw_seq_loader
    import sw_seq_loader_pkg::*;
#(
    parameter int unsigned REF_LEN   = DEF_REF_LEN,
    parameter int unsigned QUERY_LEN = DEF_QUERY_LEN,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_sel,
    output logic              sw_valid,
    output logic [NT_W-1:0]   sw_data_ref,
    output logic [NT_W-1:0]   sw_data_query,
    input  logic              sw_finish,
    output logic              busy,
    output logic              err
);

    localparam int unsigned      RIDX_W   = $clog2(REF_LEN);
    localparam int unsigned      QIDX_W   = $clog2(QUERY_LEN);
    localparam logic [CNT_W-1:0] REF_FULL = CNT_W'(REF_LEN);
    localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QUERY_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] q_cnt;
    logic [CNT_W-1:0] stream_cnt;
    logic [CNT_W-1:0] ref_cnt_nxt;
    logic [CNT_W-1:0] q_cnt_nxt;

    nt_t              ref_buf [REF_LEN];
    nt_t              q_buf   [QUERY_LEN];

    nt_t              enc_code;
    logic             enc_illegal;

    logic             ref_we;
    logic             q_we;
    logic             stream_en;
    logic             job_clear;

    sw_beat_t         beat_q;
    sw_beat_t         beat_nxt;
    logic             busy_q;
    logic             err_q;

    // ASCII -> 2-bit code for the byte currently offered by the host
    sw_nt_encoder u_encoder (
        .in_char (in_char),
        .code    (enc_code),
        .illegal (enc_illegal)
    );

    // Buffer fill levels as they will be after this edge
    assign ref_cnt_nxt = ref_cnt + (ref_we ? CNT_ONE : '0);
    assign q_cnt_nxt   = q_cnt   + (q_we   ? CNT_ONE : '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                // Leave on the edge that completes both buffers
                if ((ref_cnt_nxt == REF_FULL) && (q_cnt_nxt == Q_FULL)) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!stream_en) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sw_finish) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // FSM outputs: host handshake, buffer writes, stream advance, job clear
    always_comb begin
        in_ready  = 1'b0;
        ref_we    = 1'b0;
        q_we      = 1'b0;
        stream_en = 1'b0;
        job_clear = 1'b0;
        case (state)
            ST_LOAD: begin
                // A byte for a full buffer stalls instead of being dropped
                in_ready = in_sel ? (q_cnt < Q_FULL) : (ref_cnt < REF_FULL);
                ref_we   = in_valid & in_ready & ~in_sel;
                q_we     = in_valid & in_ready &  in_sel;
            end
            ST_STREAM: begin
                stream_en = (stream_cnt < REF_FULL);
            end
            ST_WAIT: begin
                job_clear = sw_finish;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Symbol buffers; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (ref_we) begin
            ref_buf[ref_cnt[RIDX_W-1:0]] <= enc_code;
        end
        if (q_we) begin
            q_buf[q_cnt[QIDX_W-1:0]] <= enc_code;
        end
    end

    // Next beat to the core: element k of both buffers, query zero past its end
    always_comb begin
        beat_nxt = '0;
        if (stream_en) begin
            beat_nxt.valid    = 1'b1;
            beat_nxt.data_ref = ref_buf[stream_cnt[RIDX_W-1:0]];
            if (stream_cnt < Q_FULL) begin
                beat_nxt.data_query = q_buf[stream_cnt[QIDX_W-1:0]];
            end
        end
    end

    // Counters, output registers and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt    <= '0;
            q_cnt      <= '0;
            stream_cnt <= '0;
            beat_q     <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (job_clear) begin
                ref_cnt    <= '0;
                q_cnt      <= '0;
                stream_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt_nxt;
                q_cnt   <= q_cnt_nxt;
                if (stream_en) begin
                    stream_cnt <= stream_cnt + CNT_ONE;
                end
            end

            beat_q <= beat_nxt;
            busy_q <= (state_nxt != ST_LOAD);

            if (job_clear) begin
                err_q <= 1'b0;
            end else if ((ref_we | q_we) & enc_illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sw_valid      = beat_q.valid;
    assign sw_data_ref   = beat_q.data_ref;
    assign sw_data_query = beat_q.data_query;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule : sw_seq_loader

// File: tb/tb_sw_seq_loader.sv
// ----------------------------------------------------------------------------
// tb_sw_seq_loader
// Self-checking bench for sw_seq_loader. Expected streams are computed from
// the characters the bench sent, using a plain ASCII-to-code lookup.
// ----------------------------------------------------------------------------
module tb_sw_seq_loader;

    localparam int REF_LEN   = 64;
    localparam int QUERY_LEN = 48;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       in_sel;
    logic       sw_valid;
    logic [1:0] sw_data_ref;
    logic [1:0] sw_data_query;
    logic       sw_finish;
    logic       busy;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] ref_chars[$];
    logic [7:0] q_chars[$];

    string nt_upper = "ACGT";
    string nt_lower = "acgt";
    string nt_mixed = "ACGTacgt";

    sw_seq_loader dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_char       (in_char),
        .in_sel        (in_sel),
        .sw_valid      (sw_valid),
        .sw_data_ref   (sw_data_ref),
        .sw_data_query (sw_data_query),
        .sw_finish     (sw_finish),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Reference encoding: position of the upper-cased letter in "ACGT", else 0
    function automatic logic [1:0] enc(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'd32;
        for (int i = 0; i < 4; i++) begin
            if (u == nt_upper[i]) return 2'(i);
        end
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        ref_chars.delete();
        q_chars.delete();
    endtask

    // Offer one byte and wait (bounded) until it is accepted
    task automatic send(input logic [7:0] c, input logic s);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_char  = c;
        in_sel   = s;
        #1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        check("send_accept", 32'(done), 32'd1);
        if (s) q_chars.push_back(c);
        else   ref_chars.push_back(c);
        in_valid = 1'b0;
    endtask

    // Random interleaving of ref/query bytes drawn from pool
    task automatic load_rand(input int nr, input int nq, input string pool);
        int rr;
        int rq;
        logic s;
        rr = nr;
        rq = nq;
        while (rr > 0 || rq > 0) begin
            if (rq == 0)      s = 1'b0;
            else if (rr == 0) s = 1'b1;
            else              s = 1'($urandom_range(0, 1));
            send(pool[$urandom_range(0, pool.len() - 1)], s);
            if (s) rq--;
            else   rr--;
        end
    endtask

    // Observe the serial load, starting right after the last accepted byte
    task automatic run_stream(input int finish_at, input logic exp_err, input int stop_at);
        int  wait_n;
        bit  seen;
        logic [1:0] exp_q;
        wait_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            wait_n++;
            if (sw_valid) seen = 1'b1;
        end
        check("stream_latency", 32'(wait_n), 32'd1);
        for (int k = 0; k < REF_LEN; k++) begin
            if (k == stop_at) return;
            if (k > 0) tick();
            sw_finish = (k == finish_at);
            exp_q = (k < QUERY_LEN) ? enc(q_chars[k]) : 2'b00;
            check("stream_valid", 32'(sw_valid), 32'd1);
            check("stream_ref", 32'(sw_data_ref), 32'(enc(ref_chars[k])));
            check("stream_query", 32'(sw_data_query), 32'(exp_q));
            check("stream_busy", 32'(busy), 32'd1);
            check("stream_ready", 32'(in_ready), 32'd0);
            check("stream_err", 32'(err), 32'(exp_err));
        end
        sw_finish = 1'b0;
        tick();
        check("post_valid", 32'(sw_valid), 32'd0);
        check("post_ref", 32'(sw_data_ref), 32'd0);
        check("post_query", 32'(sw_data_query), 32'd0);
        check("post_busy", 32'(busy), 32'd1);
    endtask

    // Linger in WAIT, then pulse finish and confirm return to LOAD
    task automatic finish_job(input logic exp_err);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_ready", 32'(in_ready), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
            check("wait_valid", 32'(sw_valid), 32'd0);
            check("wait_err", 32'(err), 32'(exp_err));
        end
        sw_finish = 1'b1;
        tick();
        sw_finish = 1'b0;
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_err", 32'(err), 32'd0);
        check("fin_ready", 32'(in_ready), 32'd1);
        clear_model();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_sel    = 1'b0;
        sw_finish = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(sw_valid), 32'd0);
        check("rst_ref", 32'(sw_data_ref), 32'd0);
        check("rst_query", 32'(sw_data_query), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Job 1: "ACGT..." reference, then all-T query
        for (int i = 0; i < REF_LEN; i++) send(nt_upper[i % 4], 1'b0);
        for (int i = 0; i < QUERY_LEN; i++) send(8'h54, 1'b1);
        run_stream(-1, 1'b0, REF_LEN);
        finish_job(1'b0);

        // Job 2: lowercase, interleaved; ref channel stalls once full
        load_rand(REF_LEN, QUERY_LEN - 8, nt_lower);
        in_sel = 1'b0;
        #1;
        check("ref_full_ready", 32'(in_ready), 32'd0);
        in_sel = 1'b1;
        #1;
        check("query_open_ready", 32'(in_ready), 32'd1);
        load_rand(0, 8, nt_lower);
        run_stream(-1, 1'b0, REF_LEN);
        finish_job(1'b0);

        // Job 3: illegal 'N' at ref index 5, finish pulses in LOAD and STREAM
        for (int i = 0; i < 5; i++) send(nt_mixed[$urandom_range(0, 7)], 1'b0);
        check("err_before_bad", 32'(err), 32'd0);
        send(8'h4E, 1'b0);
        check("err_after_bad", 32'(err), 32'd1);
        sw_finish = 1'b1;
        tick();
        sw_finish = 1'b0;
        check("load_fin_busy", 32'(busy), 32'd0);
        check("load_fin_err", 32'(err), 32'd1);
        check("load_fin_ready", 32'(in_ready), 32'd1);
        load_rand(REF_LEN - 6, QUERY_LEN, nt_mixed);
        run_stream(30, 1'b1, REF_LEN);
        finish_job(1'b1);

        // Job 4: byte held through STREAM/WAIT becomes element 0 of the next job
        load_rand(REF_LEN, QUERY_LEN, nt_mixed);
        in_valid = 1'b1;
        in_char  = 8'h47;
        in_sel   = 1'b0;
        run_stream(-1, 1'b0, REF_LEN);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_wait_ready", 32'(in_ready), 32'd0);
        end
        sw_finish = 1'b1;
        tick();
        sw_finish = 1'b0;
        clear_model();
        check("hold_load_ready", 32'(in_ready), 32'd1);
        check("hold_load_busy", 32'(busy), 32'd0);
        tick();
        ref_chars.push_back(8'h47);
        in_valid = 1'b0;
        load_rand(REF_LEN - 1, QUERY_LEN, nt_mixed);
        run_stream(-1, 1'b0, REF_LEN);
        finish_job(1'b0);

        // Job 5: reset at stream index 20, then a fresh full job
        load_rand(REF_LEN, QUERY_LEN, nt_mixed);
        run_stream(-1, 1'b0, 20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        check("midrst_valid", 32'(sw_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        in_sel = 1'b0;
        #1;
        check("midrst_ref_ready", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        #1;
        check("midrst_q_ready", 32'(in_ready), 32'd1);
        load_rand(REF_LEN, QUERY_LEN, nt_mixed);
        run_stream(-1, 1'b0, REF_LEN);
        finish_job(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sw_seq_loader
